shift_dispatch: RTL and testbench

- Two-stage pipelined issue/writeback stage around the 64-bit barrel shifter.
- Decodes RV64I shift instructions (SLL/SRL/SRA, SLLI/SRLI/SRAI) into the shifter's 2-bit mode code and 6-bit shift amount, and drives the shifter operand.
- Captures the shifter result into a registered output with valid/ready handshakes on both sides.
- Sits between the register-read stage and register-file writeback.

---
 rtl/shift_dispatch_if.sv | 37 +++
 rtl/shift_dispatch.sv | 185 ++++++++++++++++++
 tb/tb_shift_dispatch.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_dispatch_if.sv
// Bundles the issue, shifter and writeback signals of the shift dispatch stage.
interface shift_dispatch_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;

    logic [1:0]       sh_shift;
    logic [XLEN-1:0]  sh_entrada;
    logic [5:0]       sh_n;
    logic [XLEN-1:0]  sh_saida;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_data;
    logic [4:0]       out_rd;
    logic             out_err;
    logic [CNT_W-1:0] out_count;

    // Environment side: upstream stage, external shifter and writeback.
    modport master (
        output in_valid, in_instr, in_rs1, in_rs2, sh_saida, out_ready,
        input  in_ready, sh_shift, sh_entrada, sh_n,
               out_valid, out_data, out_rd, out_err, out_count
    );

    // Dispatch stage side.
    modport slave (
        input  in_valid, in_instr, in_rs1, in_rs2, sh_saida, out_ready,
        output in_ready, sh_shift, sh_entrada, sh_n,
               out_valid, out_data, out_rd, out_err, out_count
    );
endinterface

// File: rtl/shift_dispatch.sv
// Two-stage issue/writeback wrapper around the 64-bit barrel shifter:
// decodes RV64I shifts, drives the shifter and registers its result.
module shift_dispatch #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    shift_dispatch_if.slave bus
);
    localparam int unsigned SHAMT_W = 6;
    localparam int unsigned RD_W    = 5;
    localparam int unsigned MODE_W  = 2;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRX     = 3'b101;
    localparam logic [5:0] F6_LOGIC   = 6'b000000;
    localparam logic [5:0] F6_ARITH   = 6'b010000;
    localparam logic [6:0] F7_LOGIC   = 7'b0000000;
    localparam logic [6:0] F7_ARITH   = 7'b0100000;

    localparam logic [MODE_W-1:0] MODE_SLL  = 2'b00;
    localparam logic [MODE_W-1:0] MODE_SRL  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_SRA  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_PASS = 2'b11;

    typedef struct packed {
        logic [MODE_W-1:0]  mode;
        logic [SHAMT_W-1:0] n;
        logic [XLEN-1:0]    opnd;
        logic [RD_W-1:0]    rd;
        logic               err;
    } s1_t;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [RD_W-1:0] rd;
        logic            err;
    } s2_t;

    logic [6:0]         opcode_c;
    logic [2:0]         funct3_c;
    logic [5:0]         funct6_c;
    logic [6:0]         funct7_c;
    logic [SHAMT_W-1:0] shamt_imm_c;
    logic [SHAMT_W-1:0] shamt_reg_c;
    logic               unused_bits_c;

    s1_t                dec_c;
    s1_t                s1_q;
    s2_t                s2_d;
    s2_t                s2_q;
    logic               s1_valid_q;
    logic               s1_valid_d;
    logic               s2_valid_q;
    logic               s2_valid_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic               in_ready_c;
    logic               accept_c;
    logic               s1_adv_c;
    logic               handoff_c;

    assign opcode_c    = bus.in_instr[6:0];
    assign funct3_c    = bus.in_instr[14:12];
    assign funct6_c    = bus.in_instr[31:26];
    assign funct7_c    = bus.in_instr[31:25];
    assign shamt_imm_c = bus.in_instr[25:20];
    assign shamt_reg_c = bus.in_rs2[SHAMT_W-1:0];

    // rs1 index and high rs2 bits play no part in a shift.
    assign unused_bits_c = ^{bus.in_instr[19:15], bus.in_rs2[XLEN-1:SHAMT_W]};

    // Decode; anything that is not one of the six legal shifts passes rs1 through flagged.
    always_comb begin
        dec_c = '{mode: MODE_PASS, n: '0, opnd: bus.in_rs1,
                  rd: bus.in_instr[11:7], err: 1'b1};
        if (opcode_c == OPC_OP_IMM) begin
            if (funct3_c == F3_SLL && funct6_c == F6_LOGIC) begin
                dec_c.mode = MODE_SLL;
                dec_c.n    = shamt_imm_c;
                dec_c.err  = 1'b0;
            end else if (funct3_c == F3_SRX && funct6_c == F6_LOGIC) begin
                dec_c.mode = MODE_SRL;
                dec_c.n    = shamt_imm_c;
                dec_c.err  = 1'b0;
            end else if (funct3_c == F3_SRX && funct6_c == F6_ARITH) begin
                dec_c.mode = MODE_SRA;
                dec_c.n    = shamt_imm_c;
                dec_c.err  = 1'b0;
            end
        end else if (opcode_c == OPC_OP) begin
            if (funct3_c == F3_SLL && funct7_c == F7_LOGIC) begin
                dec_c.mode = MODE_SLL;
                dec_c.n    = shamt_reg_c;
                dec_c.err  = 1'b0;
            end else if (funct3_c == F3_SRX && funct7_c == F7_LOGIC) begin
                dec_c.mode = MODE_SRL;
                dec_c.n    = shamt_reg_c;
                dec_c.err  = 1'b0;
            end else if (funct3_c == F3_SRX && funct7_c == F7_ARITH) begin
                dec_c.mode = MODE_SRA;
                dec_c.n    = shamt_reg_c;
                dec_c.err  = 1'b0;
            end
        end
    end

    // Pipeline advance conditions; flush blocks every transfer in its cycle.
    always_comb begin
        in_ready_c = !flush && (!s1_valid_q || !s2_valid_q || bus.out_ready);
        accept_c   = bus.in_valid && in_ready_c;
        s1_adv_c   = !flush && s1_valid_q && (!s2_valid_q || bus.out_ready);
        handoff_c  = !flush && s2_valid_q && bus.out_ready;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        cnt_d      = cnt_q;
        s2_d       = '{data: bus.sh_saida, rd: s1_q.rd, err: s1_q.err};
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (accept_c) begin
                s1_valid_d = 1'b1;
            end else if (s1_adv_c) begin
                s1_valid_d = 1'b0;
            end
            if (s1_adv_c) begin
                s2_valid_d = 1'b1;
            end else if (handoff_c) begin
                s2_valid_d = 1'b0;
            end
        end
        if (handoff_c && !s2_q.err) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    // Datapath registers load only on their own stage's enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else if (accept_c) begin
            s1_q <= dec_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_q <= '0;
        end else if (s1_adv_c) begin
            s2_q <= s2_d;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.sh_shift   = s1_q.mode;
    assign bus.sh_n       = s1_q.n;
    assign bus.sh_entrada = s1_q.opnd;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_data   = s2_q.data;
    assign bus.out_rd     = s2_q.rd;
    assign bus.out_err    = s2_q.err;
    assign bus.out_count  = cnt_q;

endmodule

// File: tb/tb_shift_dispatch.sv
// Randomized bench for shift_dispatch: shifter model, directed scenarios and a
// queue-based scoreboard that predicts results straight from the ISA rules.
module tb_shift_dispatch;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_cnt = '0;

    shift_dispatch_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    shift_dispatch #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External barrel shifter.
    always_comb begin
        case (bus.sh_shift)
            2'b00:   bus.sh_saida = bus.sh_entrada << bus.sh_n;
            2'b01:   bus.sh_saida = bus.sh_entrada >> bus.sh_n;
            2'b10:   bus.sh_saida = 64'($signed(bus.sh_entrada) >>> bus.sh_n);
            default: bus.sh_saida = bus.sh_entrada;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Architectural result of one instruction.
    function automatic void ref_exec(input logic [31:0] ins, input logic [63:0] a,
                                     input logic [63:0] b, output logic [63:0] d,
                                     output logic e);
        logic [6:0] opc;
        logic [2:0] f3;
        int         sh_i;
        int         sh_r;
        opc  = ins[6:0];
        f3   = ins[14:12];
        sh_i = int'(ins[25:20]);
        sh_r = int'(b[5:0]);
        e    = 1'b0;
        if (opc == 7'h13 && f3 == 3'd1 && ins[31:26] == 6'h00)       d = a << sh_i;
        else if (opc == 7'h13 && f3 == 3'd5 && ins[31:26] == 6'h00)  d = a >> sh_i;
        else if (opc == 7'h13 && f3 == 3'd5 && ins[31:26] == 6'h10)  d = 64'($signed(a) >>> sh_i);
        else if (opc == 7'h33 && f3 == 3'd1 && ins[31:25] == 7'h00)  d = a << sh_r;
        else if (opc == 7'h33 && f3 == 3'd5 && ins[31:25] == 7'h00)  d = a >> sh_r;
        else if (opc == 7'h33 && f3 == 3'd5 && ins[31:25] == 7'h20)  d = 64'($signed(a) >>> sh_r);
        else begin
            d = a;
            e = 1'b1;
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd;
        logic [5:0]  sh;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] w;
        rd = 5'($urandom);
        sh = 6'($urandom);
        r1 = 5'($urandom);
        r2 = 5'($urandom);
        case ($urandom_range(0, 8))
            0:       w = {6'h00, sh, r1, 3'b001, rd, 7'h13};
            1:       w = {6'h00, sh, r1, 3'b101, rd, 7'h13};
            2:       w = {6'h10, sh, r1, 3'b101, rd, 7'h13};
            3:       w = {7'h00, r2, r1, 3'b001, rd, 7'h33};
            4:       w = {7'h00, r2, r1, 3'b101, rd, 7'h33};
            5:       w = {7'h20, r2, r1, 3'b101, rd, 7'h33};
            6:       w = {7'h00, sh[4:0], r1, 3'b001, rd, 7'h1b};
            7:       w = {7'h00, r2, r1, 3'b000, rd, 7'h33};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    // Scoreboard: occupancy, latency, data order and retire count.
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] d;
        logic        er;
        if (!rst_n) begin
            sb.delete();
            exp_cnt = '0;
        end else begin
            chk("count", 64'(bus.out_count), 64'(exp_cnt));
            chk("in_ready", 64'(bus.in_ready),
                64'(!flush && (sb.size() < 2 || bus.out_ready)));
            chk("out_valid", 64'(bus.out_valid),
                64'(sb.size() > 0 && cyc >= sb[0].acc + 2));
            if (bus.out_valid && sb.size() > 0) begin
                chk("out_data", bus.out_data, sb[0].data);
                chk("out_rd", 64'(bus.out_rd), 64'(sb[0].rd));
                chk("out_err", 64'(bus.out_err), 64'(sb[0].err));
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
                    if (!sb[0].err) exp_cnt = exp_cnt + 32'd1;
                    void'(sb.pop_front());
                end
                if (bus.in_valid && bus.in_ready) begin
                    ref_exec(bus.in_instr, bus.in_rs1, bus.in_rs2, d, er);
                    e.data = d;
                    e.rd   = bus.in_instr[11:7];
                    e.err  = er;
                    e.acc  = cyc;
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        bus.in_rs1   = a;
        bus.in_rs2   = b;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ins;
        logic [63:0] d0;
        logic        e0;
        int          n_acc;
        int          run;
        int          max_run;
        logic [31:0] cnt0;

        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.out_ready = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_out_rd", 64'(bus.out_rd), 64'd0);
        chk("rst_out_err", 64'(bus.out_err), 64'd0);
        chk("rst_out_count", 64'(bus.out_count), 64'd0);
        chk("rst_sh_shift", 64'(bus.sh_shift), 64'd0);
        chk("rst_sh_n", 64'(bus.sh_n), 64'd0);
        chk("rst_sh_entrada", bus.sh_entrada, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // SRAI x5, x1, 4
        bus.out_ready = 1'b1;
        issue({6'h10, 6'd4, 5'd1, 3'b101, 5'd5, 7'h13}, 64'h8000_0000_0000_0010, 64'd0);
        chk("srai_sh_shift", 64'(bus.sh_shift), 64'd2);
        chk("srai_sh_n", 64'(bus.sh_n), 64'd4);
        chk("srai_sh_entrada", bus.sh_entrada, 64'h8000_0000_0000_0010);
        step();
        chk("srai_valid", 64'(bus.out_valid), 64'd1);
        chk("srai_data", bus.out_data, 64'hF800_0000_0000_0001);
        chk("srai_rd", 64'(bus.out_rd), 64'd5);
        chk("srai_err", 64'(bus.out_err), 64'd0);
        chk("srai_count_pre", 64'(bus.out_count), 64'd0);
        step();
        chk("srai_count_post", 64'(bus.out_count), 64'd1);

        // SLL with upper rs2 bits set
        issue({7'h00, 5'd2, 5'd1, 3'b001, 5'd3, 7'h33}, 64'd1, 64'h47);
        chk("sll_sh_n", 64'(bus.sh_n), 64'd7);
        chk("sll_sh_shift", 64'(bus.sh_shift), 64'd0);
        step();
        chk("sll_data", bus.out_data, 64'h80);
        step();
        chk("sll_count", 64'(bus.out_count), 64'd2);

        // SRL by 63
        issue({7'h00, 5'd2, 5'd1, 3'b101, 5'd4, 7'h33}, 64'hFFFF_FFFF_FFFF_FFFF, 64'd63);
        step();
        chk("srl_data", bus.out_data, 64'd1);
        step();
        chk("srl_count", 64'(bus.out_count), 64'd3);

        // ADD is not a shift
        issue(32'h0000_0033, 64'h1234, 64'd0);
        step();
        chk("add_err", 64'(bus.out_err), 64'd1);
        chk("add_data", bus.out_data, 64'h1234);
        step();
        chk("add_count", 64'(bus.out_count), 64'd3);

        // Back-to-back SLLI stream
        cnt0    = exp_cnt;
        run     = 0;
        max_run = 0;
        for (int i = 0; i < 14; i++) begin
            bus.in_valid = (i < 8);
            bus.in_instr = {6'h00, 6'(i), 5'd1, 3'b001, 5'(i + 1), 7'h13};
            bus.in_rs1   = 64'(i + 1);
            @(negedge clk);
            if (bus.out_valid) run++;
            else run = 0;
            if (run > max_run) max_run = run;
            step();
        end
        bus.in_valid = 1'b0;
        chk("stream_run", 64'(max_run), 64'd8);
        chk("stream_count", 64'(bus.out_count - cnt0), 64'd8);

        // Backpressure: three offered, two fit
        bus.out_ready = 1'b0;
        n_acc         = 0;
        ref_exec({6'h00, 6'd1, 5'd1, 3'b101, 5'd10, 7'h13}, 64'hF0F0_0000_1234_5678, 64'd0, d0, e0);
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = (n_acc < 3);
            bus.in_instr = {6'h00, 6'(n_acc + 1), 5'd1, 3'b101, 5'(n_acc + 10), 7'h13};
            bus.in_rs1   = 64'hF0F0_0000_1234_5678;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) n_acc++;
            step();
        end
        chk("bp_accepted", 64'(n_acc), 64'd2);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_hold_data", bus.out_data, d0);
        step();
        chk("bp_hold_data2", bus.out_data, d0);
        chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
        cnt0          = exp_cnt;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && n_acc < 3; i++) begin
            bus.in_instr = {6'h00, 6'(n_acc + 1), 5'd1, 3'b101, 5'(n_acc + 10), 7'h13};
            @(negedge clk);
            if (bus.in_ready) n_acc++;
            step();
        end
        bus.in_valid = 1'b0;
        repeat (4) step();
        chk("bp_third", 64'(n_acc), 64'd3);
        chk("bp_drain_count", 64'(bus.out_count - cnt0), 64'd3);

        // Flush with both stages full
        bus.out_ready = 1'b0;
        issue({6'h00, 6'd3, 5'd1, 3'b001, 5'd7, 7'h13}, 64'h55, 64'd0);
        issue({6'h00, 6'd2, 5'd1, 3'b001, 5'd8, 7'h13}, 64'h66, 64'd0);
        chk("flush_pre_valid", 64'(bus.out_valid), 64'd1);
        cnt0          = exp_cnt;
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        #1 chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_count", 64'(bus.out_count), 64'(cnt0));
        step();
        chk("flush_empty", 64'(bus.out_valid), 64'd0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_instr  = rand_instr();
            bus.in_rs1    = {$urandom, $urandom};
            bus.in_rs2    = {$urandom, $urandom};
            bus.out_ready = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 39) == 0);
            step();
        end
        flush = 1'b0;

        // Reset in the middle of traffic
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        repeat (3) step();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_data", bus.out_data, 64'd0);
        chk("mid_rst_count", 64'(bus.out_count), 64'd0);
        chk("mid_rst_sh_shift", 64'(bus.sh_shift), 64'd0);
        chk("mid_rst_sh_entrada", bus.sh_entrada, 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int c = 0; c < 100; c++) begin
            bus.in_valid  = ($urandom_range(0, 1) == 1);
            bus.in_instr  = rand_instr();
            bus.in_rs1    = {$urandom, $urandom};
            bus.in_rs2    = {$urandom, $urandom};
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) step();
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_valid", 64'(bus.out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
